// File: rtl/sdiv_seq.sv
// -----------------------------------------------------------------------------
// sdiv_seq -- sequencer for an external 32/16 signed divider.
//
// Accepts a 32-bit dividend and 16-bit divisor over a valid/ready handshake,
// presents them to the divider over a 16-bit bus as three beats (dividend
// high, dividend low with St=1, then divisor with St=0), waits for the rising
// edge of the divider's Rdy level, and holds the captured result until the
// consumer takes it. A watchdog aborts the wait after TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT      maximum WAIT cycles before abort (1..255)
// Optional build macro:
//   SDIV_SEQ_DIVZERO_EN  zero divisor is answered locally (OutV=1) without
//                        starting the divider
// Ports:
//   CLK, Rst_n                    clock, async active-low reset
//   InValid/InReady               operand handshake
//   InDividend[31:0], InDivisor   signed operands
//   St, Dbus[15:0]                start strobe and operand bus to the divider
//   Quotient, Remainder, V, Rdy   divider results, overflow, done level
//   OutValid/OutReady             result handshake
//   OutQuotient, OutRemainder,
//   OutV, OutTimeout              captured result, overflow, watchdog abort
//   Busy                          sequencer is not idle
// -----------------------------------------------------------------------------
module sdiv_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        Rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InDividend,
    input  logic [15:0] InDivisor,
    output logic        St,
    output logic [15:0] Dbus,
    input  logic [15:0] Quotient,
    input  logic [15:0] Remainder,
    input  logic        V,
    input  logic        Rdy,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [15:0] OutQuotient,
    output logic [15:0] OutRemainder,
    output logic        OutV,
    output logic        OutTimeout,
    output logic        Busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LDHI  = 3'd1;
    localparam logic [2:0] S_LDLO  = 3'd2;
    localparam logic [2:0] S_LDDIV = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    // Counter runs 0..TIMEOUT-1, so WAIT lasts exactly TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

`ifdef SDIV_SEQ_DIVZERO_EN
    localparam logic DIVZERO_EN = 1'b1;
`else
    localparam logic DIVZERO_EN = 1'b0;
`endif

    logic [2:0]  r_state;
    logic [31:0] r_dividend;
    logic [15:0] r_divisor;
    logic        r_divzero;
    logic        r_rdy_q;
    logic [7:0]  r_cnt;
    logic        r_st;
    logic [15:0] r_dbus;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_out_valid;
    logic [15:0] r_out_q;
    logic [15:0] r_out_r;
    logic        r_out_v;
    logic        r_out_to;

    logic [2:0]  w_state_nxt;
    logic [31:0] w_dividend_nxt;
    logic [15:0] w_divisor_nxt;
    logic        w_divzero_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] w_out_q_nxt;
    logic [15:0] w_out_r_nxt;
    logic        w_out_v_nxt;
    logic        w_out_to_nxt;
    logic        w_st_nxt;
    logic [15:0] w_dbus_nxt;
    logic        w_done;

    // Only a fresh Rdy rising edge seen while waiting counts as completion.
    assign w_done = (r_state == S_WAIT) && Rdy && !r_rdy_q;

    // Next-state, operand latch, watchdog counter and result capture.
    always_comb begin
        w_state_nxt    = r_state;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_divzero_nxt  = r_divzero;
        w_cnt_nxt      = 8'd0;
        w_out_q_nxt    = r_out_q;
        w_out_r_nxt    = r_out_r;
        w_out_v_nxt    = r_out_v;
        w_out_to_nxt   = r_out_to;
        case (r_state)
            S_IDLE: begin
                if (InValid) begin
                    w_state_nxt    = S_LDHI;
                    w_dividend_nxt = InDividend;
                    w_divisor_nxt  = InDivisor;
                    w_divzero_nxt  = DIVZERO_EN & (InDivisor == 16'd0);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LDHI: begin
                // A locally answered zero divisor never starts the divider.
                if (r_divzero) begin
                    w_state_nxt  = S_HOLD;
                    w_out_q_nxt  = 16'd0;
                    w_out_r_nxt  = 16'd0;
                    w_out_v_nxt  = 1'b1;
                    w_out_to_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_LDLO;
                end
            end
            S_LDLO:  w_state_nxt = S_LDDIV;
            S_LDDIV: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // Completion takes priority over the watchdog on the same edge.
                if (w_done) begin
                    w_state_nxt  = S_HOLD;
                    w_out_q_nxt  = Quotient;
                    w_out_r_nxt  = Remainder;
                    w_out_v_nxt  = V;
                    w_out_to_nxt = 1'b0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt  = S_HOLD;
                    w_out_q_nxt  = 16'd0;
                    w_out_r_nxt  = 16'd0;
                    w_out_v_nxt  = 1'b1;
                    w_out_to_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (OutReady) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Divider bus contents for the upcoming state, so St/Dbus leave a flop.
    always_comb begin
        w_st_nxt   = 1'b0;
        w_dbus_nxt = 16'd0;
        case (w_state_nxt)
            S_LDHI: begin
                w_st_nxt   = !w_divzero_nxt;
                w_dbus_nxt = w_dividend_nxt[31:16];
            end
            S_LDLO: begin
                w_st_nxt   = 1'b1;
                w_dbus_nxt = w_dividend_nxt[15:0];
            end
            S_LDDIV, S_WAIT, S_HOLD: begin
                w_st_nxt   = 1'b0;
                w_dbus_nxt = w_divisor_nxt;
            end
            default: begin
                w_st_nxt   = 1'b0;
                w_dbus_nxt = 16'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_dividend  <= 32'd0;
            r_divisor   <= 16'd0;
            r_divzero   <= 1'b0;
            r_rdy_q     <= 1'b0;
            r_cnt       <= 8'd0;
            r_st        <= 1'b0;
            r_dbus      <= 16'd0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_q     <= 16'd0;
            r_out_r     <= 16'd0;
            r_out_v     <= 1'b0;
            r_out_to    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dividend  <= w_dividend_nxt;
            r_divisor   <= w_divisor_nxt;
            r_divzero   <= w_divzero_nxt;
            r_rdy_q     <= Rdy;
            r_cnt       <= w_cnt_nxt;
            r_st        <= w_st_nxt;
            r_dbus      <= w_dbus_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_out_valid <= (w_state_nxt == S_HOLD);
            r_out_q     <= w_out_q_nxt;
            r_out_r     <= w_out_r_nxt;
            r_out_v     <= w_out_v_nxt;
            r_out_to    <= w_out_to_nxt;
        end
    end

    assign InReady      = r_in_ready;
    assign St           = r_st;
    assign Dbus         = r_dbus;
    assign OutValid     = r_out_valid;
    assign OutQuotient  = r_out_q;
    assign OutRemainder = r_out_r;
    assign OutV         = r_out_v;
    assign OutTimeout   = r_out_to;
    assign Busy         = r_busy;

endmodule

// File: tb/tb_sdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_sdiv_seq -- self-checking bench for sdiv_seq (TIMEOUT=10).
// The bench plays the divider: it drives Rdy/Quotient/Remainder/V itself and
// pushes the result it expects onto a scoreboard when an operand pair is
// offered; a monitor pops and compares on each result handshake.
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_sdiv_seq;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        v;
        logic        to;
    } res_t;

    logic        CLK;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [31:0] InDividend;
    logic [15:0] InDivisor;
    logic        St;
    logic [15:0] Dbus;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        V;
    logic        Rdy;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutQuotient;
    logic [15:0] OutRemainder;
    logic        OutV;
    logic        OutTimeout;
    logic        Busy;

    int   n_cmp = 0;
    int   n_mis = 0;
    res_t sb_q[$];

    sdiv_seq #(.TIMEOUT(10)) dut (
        .CLK          (CLK),
        .Rst_n        (Rst_n),
        .InValid      (InValid),
        .InReady      (InReady),
        .InDividend   (InDividend),
        .InDivisor    (InDivisor),
        .St           (St),
        .Dbus         (Dbus),
        .Quotient     (Quotient),
        .Remainder    (Remainder),
        .V            (V),
        .Rdy          (Rdy),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutQuotient  (OutQuotient),
        .OutRemainder (OutRemainder),
        .OutV         (OutV),
        .OutTimeout   (OutTimeout),
        .Busy         (Busy)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] q, input logic [15:0] r, input logic v, input logic to);
        res_t e;
        e.q  = q;
        e.r  = r;
        e.v  = v;
        e.to = to;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every result handshake pops and compares one expectation.
    always @(negedge CLK) begin
        if (Rst_n && OutValid && OutReady) begin
            check_eq("sb_pending", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                res_t e;
                e = sb_q.pop_front();
                check_eq("sb_quotient",  {16'd0, OutQuotient},  {16'd0, e.q});
                check_eq("sb_remainder", {16'd0, OutRemainder}, {16'd0, e.r});
                check_eq("sb_v",         {31'd0, OutV},         {31'd0, e.v});
                check_eq("sb_timeout",   {31'd0, OutTimeout},   {31'd0, e.to});
            end
        end
    end

    task automatic drive_accept(input logic [31:0] dend, input logic [15:0] dsr, input logic keep_rdy);
        tick();
        if (!keep_rdy) Rdy = 1'b0;
        InValid    = 1'b1;
        InDividend = dend;
        InDivisor  = dsr;
        @(negedge CLK);
        check_eq("accept_ready", {31'd0, InReady}, 32'd1);
        tick();
        InValid    = 1'b0;
        InDividend = $urandom;
        InDivisor  = 16'($urandom);
    endtask

    // Three bus beats following the accept edge; ends at the LDDIV negedge.
    task automatic check_load(input logic [31:0] dend, input logic [15:0] dsr);
        @(negedge CLK);
        check_eq("ldhi_st",   {31'd0, St},   32'd1);
        check_eq("ldhi_dbus", {16'd0, Dbus}, {16'd0, dend[31:16]});
        tick();
        @(negedge CLK);
        check_eq("ldlo_st",   {31'd0, St},   32'd1);
        check_eq("ldlo_dbus", {16'd0, Dbus}, {16'd0, dend[15:0]});
        tick();
        @(negedge CLK);
        check_eq("lddiv_st",   {31'd0, St},   32'd0);
        check_eq("lddiv_dbus", {16'd0, Dbus}, {16'd0, dsr});
    endtask

    // Entered at the first negedge with OutValid=1; holds, then hands off.
    task automatic finish_result(input logic [15:0] q, input logic [15:0] r, input logic v,
                                 input logic to, input int hold);
        for (int i = 0; i <= hold; i++) begin
            check_eq("hold_valid",    {31'd0, OutValid},     32'd1);
            check_eq("hold_inready",  {31'd0, InReady},      32'd0);
            check_eq("hold_busy",     {31'd0, Busy},         32'd1);
            check_eq("hold_st",       {31'd0, St},           32'd0);
            check_eq("hold_quotient", {16'd0, OutQuotient},  {16'd0, q});
            check_eq("hold_remainder",{16'd0, OutRemainder}, {16'd0, r});
            check_eq("hold_v",        {31'd0, OutV},         {31'd0, v});
            check_eq("hold_timeout",  {31'd0, OutTimeout},   {31'd0, to});
            if (i < hold) begin
                tick();
                @(negedge CLK);
            end
        end
        tick();
        OutReady = 1'b1;
        @(negedge CLK);
        check_eq("take_valid", {31'd0, OutValid}, 32'd1);
        tick();
        OutReady = 1'b0;
        @(negedge CLK);
        check_eq("idle_inready", {31'd0, InReady},  32'd1);
        check_eq("idle_valid",   {31'd0, OutValid}, 32'd0);
        check_eq("idle_busy",    {31'd0, Busy},     32'd0);
        check_eq("idle_st",      {31'd0, St},       32'd0);
        check_eq("idle_dbus",    {16'd0, Dbus},     32'd0);
    endtask

    task automatic run_op(input logic [31:0] dend, input logic [15:0] dsr,
                          input logic [15:0] q, input logic [15:0] r, input logic v,
                          input int lat, input int hold, input logic pre_high);
        drive_accept(dend, dsr, pre_high);
        push_exp(q, r, v, 1'b0);
        check_load(dend, dsr);
        if (pre_high) begin
            // Rdy has been high all along: no capture until it falls and rises.
            repeat (3) begin
                tick();
                @(negedge CLK);
                check_eq("prehigh_nocap", {31'd0, OutValid}, 32'd0);
            end
            tick();
            Rdy = 1'b0;
            @(negedge CLK);
            check_eq("prehigh_low", {31'd0, OutValid}, 32'd0);
        end else begin
            for (int i = 0; i < lat; i++) begin
                tick();
                @(negedge CLK);
                check_eq("wait_no_valid", {31'd0, OutValid}, 32'd0);
            end
        end
        tick();
        Quotient  = q;
        Remainder = r;
        V         = v;
        Rdy       = 1'b1;
        @(negedge CLK);
        check_eq("rdy_cycle_valid", {31'd0, OutValid}, 32'd0);
        tick();
        @(negedge CLK);
        check_eq("done_latency", {31'd0, OutValid}, 32'd1);
        finish_result(q, r, v, 1'b0, hold);
    endtask

    // Watchdog: WAIT lasts 10 cycles; optionally Rdy rises on the last one.
    task automatic run_timeout(input logic coincide);
        drive_accept(32'h00010000, 16'h0003, 1'b0);
        if (coincide) push_exp(16'h1111, 16'h2222, 1'b0, 1'b0);
        else          push_exp(16'h0000, 16'h0000, 1'b1, 1'b1);
        check_load(32'h00010000, 16'h0003);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (coincide && k == 10) begin
                Quotient  = 16'h1111;
                Remainder = 16'h2222;
                V         = 1'b0;
                Rdy       = 1'b1;
            end
            @(negedge CLK);
            check_eq("wd_wait_no_valid", {31'd0, OutValid}, 32'd0);
        end
        tick();
        @(negedge CLK);
        check_eq("wd_latency", {31'd0, OutValid}, 32'd1);
        if (coincide) finish_result(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
        else          finish_result(16'h0000, 16'h0000, 1'b1, 1'b1, 2);
    endtask

    initial begin
        Rst_n      = 1'b0;
        InValid    = 1'b0;
        InDividend = 32'd0;
        InDivisor  = 16'd0;
        Quotient   = 16'd0;
        Remainder  = 16'd0;
        V          = 1'b0;
        Rdy        = 1'b0;
        OutReady   = 1'b0;
        repeat (2) @(posedge CLK);
        #1 Rst_n = 1'b1;
        @(negedge CLK);
        check_eq("rst_st",       {31'd0, St},           32'd0);
        check_eq("rst_dbus",     {16'd0, Dbus},         32'd0);
        check_eq("rst_valid",    {31'd0, OutValid},     32'd0);
        check_eq("rst_inready",  {31'd0, InReady},      32'd1);
        check_eq("rst_busy",     {31'd0, Busy},         32'd0);
        check_eq("rst_quotient", {16'd0, OutQuotient},  32'd0);
        check_eq("rst_remainder",{16'd0, OutRemainder}, 32'd0);
        check_eq("rst_v",        {31'd0, OutV},         32'd0);
        check_eq("rst_timeout",  {31'd0, OutTimeout},   32'd0);

        // 111 / 7 = 15 r 6
        run_op(32'h0000006F, 16'h0007, 16'h000F, 16'h0006, 1'b0, 0, 0, 1'b0);
        // 134152379 / -8187 = -16386 r 197, consumer stalls 5 cycles
        run_op(32'h07FF00BB, 16'hE005, 16'hBFFE, 16'h00C5, 1'b0, 2, 5, 1'b0);
        // Rdy left high from the previous operation
        run_op(32'h12345678, 16'h0100, 16'h7FFF, 16'h0042, 1'b1, 0, 1, 1'b1);
        // Watchdog abort, then done and watchdog on the same edge
        run_timeout(1'b0);
        run_timeout(1'b1);

        // Asynchronous reset in the middle of WAIT
        drive_accept(32'h0ABCDEF0, 16'h0123, 1'b0);
        check_load(32'h0ABCDEF0, 16'h0123);
        tick();
        tick();
        @(negedge CLK);
        #2 Rst_n = 1'b0;
        #1;
        check_eq("midrst_st",       {31'd0, St},          32'd0);
        check_eq("midrst_dbus",     {16'd0, Dbus},        32'd0);
        check_eq("midrst_valid",    {31'd0, OutValid},    32'd0);
        check_eq("midrst_inready",  {31'd0, InReady},     32'd1);
        check_eq("midrst_busy",     {31'd0, Busy},        32'd0);
        check_eq("midrst_quotient", {16'd0, OutQuotient}, 32'd0);
        @(posedge CLK);
        #1 Rst_n = 1'b1;
        @(negedge CLK);
        check_eq("postrst_inready", {31'd0, InReady}, 32'd1);
        // -100 / 7 = -14 r -2
        run_op(32'hFFFFFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1, 0, 1'b0);

        // Zero divisor
`ifdef SDIV_SEQ_DIVZERO_EN
        drive_accept(32'hFFFFFFFF, 16'h0000, 1'b0);
        push_exp(16'h0000, 16'h0000, 1'b1, 1'b0);
        @(negedge CLK);
        check_eq("dz_no_st",    {31'd0, St},       32'd0);
        check_eq("dz_no_valid", {31'd0, OutValid}, 32'd0);
        tick();
        @(negedge CLK);
        check_eq("dz_valid", {31'd0, OutValid}, 32'd1);
        finish_result(16'h0000, 16'h0000, 1'b1, 1'b0, 1);
`else
        run_op(32'hFFFFFFFF, 16'h0000, 16'hAAAA, 16'h5555, 1'b1, 1, 0, 1'b0);
`endif

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
